// File: rtl/calculate_layer3_acc.sv
`default_nettype none
// ============================================================================
// Module  : calculate_layer3_acc
// Brief   : Layer-3 MAC accumulator: bias + N_TAPS products, round, saturate,
//           optional ReLU, streamed out over a valid/ready result port.
// Revision: 1.0 - initial release
// ============================================================================
module calculate_layer3_acc #(
   parameter int PROD_WIDTH = 26,
   parameter int ACC_WIDTH  = 40,
   parameter int OUT_WIDTH  = 16,
   parameter int N_TAPS     = 150,
   parameter int SHIFT      = 8,
   parameter int RELU       = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic [OUT_WIDTH-1:0]  bias,
   input  logic [PROD_WIDTH-1:0] prod_tdata,
   input  logic                  prod_tvalid,
   output logic                  prod_tready,
   output logic [OUT_WIDTH-1:0]  res_tdata,
   output logic                  res_tvalid,
   input  logic                  res_tready,
   output logic                  busy
);

   localparam logic [1:0]  c_idle  = 2'd0;
   localparam logic [1:0]  c_acc   = 2'd1;
   localparam logic [1:0]  c_out   = 2'd2;
   localparam logic [11:0] c_ntaps = 12'(N_TAPS);
   localparam int          c_ew    = ACC_WIDTH + 1;

   localparam logic signed [c_ew-1:0] c_max =
      {{(c_ew-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [c_ew-1:0] c_min =
      {{(c_ew-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic [1:0]                   r_state;
   logic [1:0]                   w_state_nxt;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
   logic [11:0]                  r_cnt;
   logic [11:0]                  w_cnt_nxt;
   logic [OUT_WIDTH-1:0]         r_res;
   logic                         w_pin;
   logic signed [ACC_WIDTH-1:0]  w_prod_ext;
   logic signed [ACC_WIDTH-1:0]  w_bias_ext;
   logic signed [ACC_WIDTH-1:0]  w_bias_sh;
   logic signed [c_ew-1:0]       w_rnd;
   logic signed [c_ew-1:0]       w_shf;
   logic [OUT_WIDTH-1:0]         w_sat;

   assign w_pin      = prod_tvalid & prod_tready;
   assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
   assign w_bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias};
   assign w_bias_sh  = w_bias_ext <<< SHIFT;

   // State register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) r_state <= c_idle;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle, c_acc: begin
            if (w_pin) w_state_nxt = (w_cnt_nxt == c_ntaps) ? c_out : c_acc;
         end
         c_out: begin
            if (res_tvalid && res_tready) w_state_nxt = c_idle;
         end
         default: w_state_nxt = c_idle;
      endcase
   end

   // Output logic
   always_comb begin
      prod_tready = (r_state != c_out);
      res_tvalid  = (r_state == c_out);
      busy        = (r_state != c_idle);
   end

   // First accepted product restarts the sum from the scaled bias
   always_comb begin
      w_acc_nxt = r_acc;
      w_cnt_nxt = r_cnt;
      if (w_pin) begin
         if (r_state == c_idle) begin
            w_acc_nxt = w_bias_sh + w_prod_ext;
            w_cnt_nxt = 12'd1;
         end else begin
            w_acc_nxt = r_acc + w_prod_ext;
            w_cnt_nxt = r_cnt + 12'd1;
         end
      end
   end

   generate
      if (SHIFT > 0) begin : g_round
         localparam logic [c_ew-1:0] c_half = c_ew'(1) << (SHIFT - 1);
         assign w_rnd = $signed({w_acc_nxt[ACC_WIDTH-1], w_acc_nxt}) + $signed(c_half);
      end else begin : g_noround
         assign w_rnd = $signed({w_acc_nxt[ACC_WIDTH-1], w_acc_nxt});
      end
   endgenerate

   assign w_shf = w_rnd >>> SHIFT;

   always_comb begin
      if (w_shf > c_max)      w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (w_shf < c_min) w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                    w_sat = w_shf[OUT_WIDTH-1:0];
      if (RELU != 0 && w_sat[OUT_WIDTH-1]) w_sat = '0;
   end

   // The result is captured on the edge that enters OUT and held until taken
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_res <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         r_cnt <= w_cnt_nxt;
         if (r_state != c_out && w_state_nxt == c_out) r_res <= w_sat;
      end
   end

   assign res_tdata = r_res;

endmodule
`default_nettype wire

// File: tb/tb_calculate_layer3_acc.sv
`default_nettype none
// Scoreboard bench: two 4-tap instances (ReLU on/off) share stimulus,
// a third 1-tap instance covers the single-product case.
module tb_calculate_layer3_acc;

   logic               ap_clk = 1'b0;
   logic               ap_rst = 1'b1;
   logic signed [15:0] bias = '0;
   logic [25:0]        prod_tdata = '0;
   logic               prod_tvalid = 1'b0;
   logic               res_tready = 1'b1;

   logic               prod_tready_a, res_tvalid_a, busy_a;
   logic signed [15:0] res_tdata_a;
   logic               prod_tready_b, res_tvalid_b, busy_b;
   logic signed [15:0] res_tdata_b;

   logic signed [15:0] bias_c = '0;
   logic [25:0]        prod_tdata_c = '0;
   logic               prod_tvalid_c = 1'b0;
   logic               res_tready_c = 1'b1;
   logic               prod_tready_c, res_tvalid_c, busy_c;
   logic signed [15:0] res_tdata_c;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     n_xa = 0;
   longint q_a[$];
   longint q_b[$];
   longint q_c[$];

   always #5 ap_clk = ~ap_clk;

   calculate_layer3_acc #(.N_TAPS(4), .RELU(1)) dut_a (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .bias(bias),
      .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready_a),
      .res_tdata(res_tdata_a), .res_tvalid(res_tvalid_a), .res_tready(res_tready),
      .busy(busy_a));

   calculate_layer3_acc #(.N_TAPS(4), .RELU(0)) dut_b (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .bias(bias),
      .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready_b),
      .res_tdata(res_tdata_b), .res_tvalid(res_tvalid_b), .res_tready(res_tready),
      .busy(busy_b));

   calculate_layer3_acc #(.N_TAPS(1), .RELU(1)) dut_c (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .bias(bias_c),
      .prod_tdata(prod_tdata_c), .prod_tvalid(prod_tvalid_c), .prod_tready(prod_tready_c),
      .res_tdata(res_tdata_c), .res_tvalid(res_tvalid_c), .res_tready(res_tready_c),
      .busy(busy_c));

   task automatic check(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // bias*2^8 + sum, round half up, saturate to 16 bits, optional ReLU
   function automatic longint exp_res(input longint b, input longint s, input bit relu);
      longint r;
      r = (b * 256 + s + 128) >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return r;
   endfunction

   // Result monitors sample mid-cycle, where inputs and outputs are settled
   always @(negedge ap_clk) begin
      if (!ap_rst && res_tvalid_a) begin
         if (q_a.size() == 0) check("unexpected_res_a", 1, 0);
         else if (res_tready) begin
            check("res_a", res_tdata_a, q_a.pop_front());
            n_xa++;
         end else check("hold_a", res_tdata_a, q_a[0]);
      end
   end

   always @(negedge ap_clk) begin
      if (!ap_rst && res_tvalid_b) begin
         if (q_b.size() == 0) check("unexpected_res_b", 1, 0);
         else if (res_tready) check("res_b", res_tdata_b, q_b.pop_front());
         else check("hold_b", res_tdata_b, q_b[0]);
      end
   end

   always @(negedge ap_clk) begin
      if (!ap_rst && res_tvalid_c && res_tready_c) begin
         if (q_c.size() == 0) check("unexpected_res_c", 1, 0);
         else check("res_c", res_tdata_c, q_c.pop_front());
      end
   end

   task automatic push_prod(input longint d, input int gap);
      int g;
      prod_tvalid = 1'b0;
      repeat (gap) begin @(posedge ap_clk); #1; end
      prod_tdata  = 26'(d);
      prod_tvalid = 1'b1;
      g = 0;
      while (!prod_tready_a && g < 50) begin @(posedge ap_clk); #1; g++; end
      if (g >= 50) check("prod_ready_timeout", 0, 1);
      @(posedge ap_clk); #1;
      prod_tvalid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while (busy_a && g < 50) begin @(posedge ap_clk); #1; g++; end
      check(tag, busy_a, 0);
   endtask

   task automatic run_seq(input longint b, input longint p[4], input int gap, input int hold);
      longint s;
      int     x0;
      s = 0;
      for (int i = 0; i < 4; i++) s += p[i];
      q_a.push_back(exp_res(b, s, 1'b1));
      q_b.push_back(exp_res(b, s, 1'b0));
      x0 = n_xa;
      res_tready = (hold == 0);
      bias = 16'(b);
      for (int i = 0; i < 4; i++) begin
         push_prod(p[i], (i == 0) ? 0 : gap);
         bias = 16'sh1234;
      end
      check("latency_valid", res_tvalid_a, 1);
      check("out_not_ready", prod_tready_a, 0);
      if (hold > 0) begin
         repeat (hold) @(posedge ap_clk);
         #1;
         res_tready = 1'b1;
      end
      wait_idle("seq_idle");
      check("one_xfer", n_xa - x0, 1);
      check("ready_after_out", prod_tready_a, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_valid", res_tvalid_a, 0);
      check("rst_data", res_tdata_a, 0);
      ap_rst = 1'b0;
      check("rst_ready", prod_tready_a, 1);

      run_seq(1, '{256, 256, 256, 256}, 0, 0);
      run_seq(0, '{-1000, -1000, -1000, -1000}, 0, 0);
      run_seq(0, '{64'sd16777216, 64'sd16777216, 64'sd16777216, 64'sd16777216}, 0, 0);
      run_seq(0, '{-64'sd16777216, -64'sd16777216, -64'sd16777216, -64'sd16777216}, 0, 0);
      run_seq(1, '{256, 256, 256, 256}, 2, 5);
      run_seq(-3, '{1000, -20000, 300000, -7}, 1, 2);

      // Reset mid-accumulation discards the partial sum
      bias = 16'sd100;
      push_prod(256, 0);
      push_prod(256, 0);
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      check("midacc_rst_busy", busy_a, 0);
      run_seq(0, '{256, 256, 256, 256}, 0, 0);

      // Reset while a result is pending drops it without a valid pulse
      res_tready = 1'b0;
      for (int i = 0; i < 4; i++) push_prod(5000, 0);
      check("pending_valid", res_tvalid_a, 1);
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      res_tready = 1'b1;
      check("out_rst_valid", res_tvalid_a, 0);
      repeat (3) @(posedge ap_clk);
      #1;
      check("out_rst_no_pulse", res_tvalid_a, 0);

      // Reset wins over a simultaneous product transfer
      prod_tdata  = 26'd256;
      prod_tvalid = 1'b1;
      ap_rst      = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst      = 1'b0;
      prod_tvalid = 1'b0;
      check("rst_prio_busy", busy_a, 0);

      // Single-tap instance
      for (int k = 0; k < 3; k++) begin
         longint bb, pp;
         int     g;
         bb = (k == 0) ? 2 : (k == 1) ? 0 : -1;
         pp = (k == 0) ? 128 : (k == 1) ? 383 : -40;
         q_c.push_back(exp_res(bb, pp, 1'b1));
         bias_c        = 16'(bb);
         prod_tdata_c  = 26'(pp);
         prod_tvalid_c = 1'b1;
         @(posedge ap_clk); #1;
         prod_tvalid_c = 1'b0;
         check("n1_latency", res_tvalid_c, 1);
         g = 0;
         while (busy_c && g < 20) begin @(posedge ap_clk); #1; g++; end
         check("n1_idle", busy_c, 0);
      end

      repeat (2) @(posedge ap_clk);
      #1;
      check("q_a_empty", q_a.size(), 0);
      check("q_b_empty", q_b.size(), 0);
      check("q_c_empty", q_c.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
